// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU op sequencer.
//   - ALUControl encodings understood by the existing ALU
//   - is_legal_op(): true for encodings the ALU implements
//   - cmd_t: one queued register-level ALU command (51 bits)
//   - state_t: sequencer FSM states
package alu_seq_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic [2:0]  op;
        logic        use_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of cmd_t entries.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data: enqueue request and data (ignored while full)
//   pop, rd_data : dequeue request (ignored while empty); rd_data shows the head
//   full, empty  : derived from the registered occupancy count
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wr_data,
    input  logic pop,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues register-level ALU commands and sequences the
// regfile / ALU-mux / ALU datapath, one op every two cycles (ISSUE, WRITE).
//   cmd_*        : command input (valid/ready)
//   A1, A2, A3   : regfile read/write addresses
//   ImmExt/ALUsrc/ALUControl : ALU mux and ALU control, valid in ISSUE
//   ALUResult    : combinational result of the datapath, sampled at end of ISSUE
//   WD3/RegWrite : regfile write-back, valid in WRITE
//   done_*       : one-cycle completion report, valid in WRITE
//   busy         : FIFO non-empty or FSM not idle
//   retired      : completed-op counter, wraps
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_use_imm,
    input  logic [4:0]       cmd_rd,
    input  logic [4:0]       cmd_rs1,
    input  logic [4:0]       cmd_rs2,
    input  logic [31:0]      cmd_imm,
    output logic [4:0]       A1,
    output logic [4:0]       A2,
    output logic [4:0]       A3,
    output logic [31:0]      ImmExt,
    output logic             ALUsrc,
    output logic [2:0]       ALUControl,
    input  logic [31:0]      ALUResult,
    output logic [31:0]      WD3,
    output logic             RegWrite,
    output logic             done_valid,
    output logic [4:0]       done_rd,
    output logic [31:0]      done_result,
    output logic             done_err,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    cmd_t       cmd_in;
    cmd_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic [4:0] op_rd;
    logic [2:0] op_code;
    logic       reg_write_q;
    logic       done_valid_q;

    // Handshake: a command transfers at the posedge where cmd_valid && cmd_ready
    // are both high; cmd_ready depends only on registered FIFO fullness (and rst),
    // never on cmd_valid.
    assign cmd_ready = !fifo_full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign cmd_in    = '{op: cmd_op, use_imm: cmd_use_imm, rd: cmd_rd,
                         rs1: cmd_rs1, rs2: cmd_rs2, imm: cmd_imm};

    // The head is popped on every entry into ISSUE.
    assign pop = !fifo_empty && ((state == ST_IDLE) || (state == ST_WRITE));

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Write enable and completion are masked by rst so a reset landing in WRITE
    // discards the in-flight op before the regfile commits it.
    assign RegWrite   = reg_write_q && !rst;
    assign done_valid = done_valid_q && !rst;
    assign busy       = !rst && (!fifo_empty || (state != ST_IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_rd        <= '0;
            op_code      <= '0;
            A1           <= '0;
            A2           <= '0;
            A3           <= '0;
            ImmExt       <= '0;
            ALUsrc       <= 1'b0;
            ALUControl   <= '0;
            WD3          <= '0;
            reg_write_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_rd      <= '0;
            done_result  <= '0;
            done_err     <= 1'b0;
            retired      <= '0;
        end else begin
            // Datapath controls are zero unless the next state loads them.
            A1           <= '0;
            A2           <= '0;
            A3           <= '0;
            ImmExt       <= '0;
            ALUsrc       <= 1'b0;
            ALUControl   <= '0;
            WD3          <= '0;
            reg_write_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_rd      <= '0;
            done_result  <= '0;
            done_err     <= 1'b0;
            case (state)
                ST_IDLE, ST_WRITE: begin
                    if (state == ST_WRITE) begin
                        retired <= retired + CNT_W'(1);
                    end
                    if (pop) begin
                        state      <= ST_ISSUE;
                        op_rd      <= head.rd;
                        op_code    <= head.op;
                        A1         <= head.rs1;
                        A2         <= head.rs2;
                        ImmExt     <= head.imm;
                        ALUsrc     <= head.use_imm;
                        ALUControl <= head.op;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // ALUResult settles during ISSUE; capture it straight into
                    // the write-back and completion registers.
                    state        <= ST_WRITE;
                    A3           <= op_rd;
                    WD3          <= ALUResult;
                    reg_write_q  <= (op_rd != 5'd0) && is_legal_op(op_code);
                    done_valid_q <= 1'b1;
                    done_rd      <= op_rd;
                    done_result  <= ALUResult;
                    done_err     <= !is_legal_op(op_code);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
